// File: rtl/mseries_sync_if.sv
// ---------------------------------------------------------------------------
// mseries_sync_if
//   Bus between a demodulator bit source and the m-sequence lock checker.
//
//   Parameter
//     CW            : width of the error counter; must match the checker's CW.
//
//   Signals
//     din_sig       : received hard-decision bit
//     din_valid_sig : din_sig is meaningful on this clock
//     lock_sig      : checker is locked to the PN sequence
//     err_sig       : one-cycle bit-error pulse (only while locked)
//     err_cnt_sig   : saturating error count since the last lock acquisition
//     inv_sig       : locked sequence is inverted (180-degree ambiguity)
//
//   Modports
//     master : bit source (drives data, observes status)
//     slave  : checker (consumes data, drives status)
// ---------------------------------------------------------------------------
interface mseries_sync_if #(
  parameter int CW = 16
);
  logic          din_sig;
  logic          din_valid_sig;
  logic          lock_sig;
  logic          err_sig;
  logic [CW-1:0] err_cnt_sig;
  logic          inv_sig;

  modport master (
    output din_sig,
    output din_valid_sig,
    input  lock_sig,
    input  err_sig,
    input  err_cnt_sig,
    input  inv_sig
  );

  modport slave (
    input  din_sig,
    input  din_valid_sig,
    output lock_sig,
    output err_sig,
    output err_cnt_sig,
    output inv_sig
  );
endinterface

// File: rtl/mseries_sync.sv
// ---------------------------------------------------------------------------
// mseries_sync
//   Self-synchronising m-sequence checker for the demodulator output.
//   Each received bit is predicted from the previous N received bits using
//   the generator recurrence. After LOCK_CNT consecutive correct predictions
//   the checker locks, then flags every mismatch as a bit error and drops
//   lock when UNLOCK_TH errors land inside one WIN-bit monitor window.
//
//   Parameters
//     N         : LFSR degree / history width (>= 2)
//     TAPS      : bit i set => b[k-(i+1)] feeds the prediction
//     LOCK_CNT  : consecutive good predictions needed to lock
//     WIN       : monitor window length in valid bits (>= 2)
//     UNLOCK_TH : errors within one window that force loss of lock
//     CW        : error counter width (must match the interface CW)
//
//   Ports
//     clk_sig   : clock, rising edge
//     rst_sig   : synchronous active-high reset
//     bus       : mseries_sync_if.slave (din/valid in; lock/err/count/inv out)
//
//   Build option
//     MSYNC_INVERT_EN : when defined, the checker also hunts for the
//                       bit-inverted sequence and reports it on inv_sig.
//                       When undefined, inv_sig is constant 0.
//
//   All outputs are registered: a valid bit sampled on edge k is reflected
//   on the outputs right after edge k.
// ---------------------------------------------------------------------------
module mseries_sync #(
  parameter int           N         = 4,
  parameter logic [N-1:0] TAPS      = 4'b1100,
  parameter int           LOCK_CNT  = 8,
  parameter int           WIN       = 32,
  parameter int           UNLOCK_TH = 4,
  parameter int           CW        = 16
) (
  input  logic          clk_sig,
  input  logic          rst_sig,
  mseries_sync_if.slave bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCK   = 2'd2
  } state_t;

  localparam int FW = $clog2(N + 1);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(UNLOCK_TH + 1);

  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WIN - 1);
  localparam logic [EW-1:0] ERR_LAST  = EW'(UNLOCK_TH - 1);

  // Error counter increment that sticks at all-ones.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = (&v) ? v : v + CW'(1);
    return r;
  endfunction

  // Registered state (one stage: sample edge -> outputs)
  state_t        state_p1,   state_nx;
  logic [N-1:0]  hist_p1,    hist_nx;
  logic [FW-1:0] fill_p1,    fill_nx;
  logic [RW-1:0] run_p1,     run_nx;
  logic [WW-1:0] win_cnt_p1, win_cnt_nx;
  logic [EW-1:0] win_err_p1, win_err_nx;
  logic          lock_p1,    lock_nx;
  logic          err_p1,     err_nx;
  logic [CW-1:0] err_cnt_p1, err_cnt_nx;
  logic          inv_p1,     inv_nx;
`ifdef MSYNC_INVERT_EN
  logic [RW-1:0] irun_p1,    irun_nx;
`endif

  // Prediction from the current history (before this bit is shifted in).
  logic pred;
  logic match_pos;
  logic match_neg;
  logic match;

  assign pred      = ^(hist_p1 & TAPS);
  assign match_pos = (bus.din_sig == pred);
  assign match_neg = (bus.din_sig != pred);
  assign match     = inv_p1 ? match_neg : match_pos;

  // Next-state / output logic
  always_comb begin
    state_nx   = state_p1;
    hist_nx    = hist_p1;
    fill_nx    = fill_p1;
    run_nx     = run_p1;
    win_cnt_nx = win_cnt_p1;
    win_err_nx = win_err_p1;
    lock_nx    = lock_p1;
    err_nx     = 1'b0;
    err_cnt_nx = err_cnt_p1;
    inv_nx     = inv_p1;
`ifdef MSYNC_INVERT_EN
    irun_nx    = irun_p1;
`endif

    if (bus.din_valid_sig) begin
      // History shifts in every state; hist[0] is the newest bit.
      hist_nx = {hist_p1[N-2:0], bus.din_sig};

      case (state_p1)
        SEARCH: begin
          fill_nx = fill_p1 + FW'(1);
          if (fill_p1 == FILL_LAST) begin
            state_nx = CHECK;
            run_nx   = '0;
`ifdef MSYNC_INVERT_EN
            irun_nx  = '0;
`endif
          end
        end

        CHECK: begin
          run_nx = match_pos ? run_p1 + RW'(1) : '0;
`ifdef MSYNC_INVERT_EN
          irun_nx = match_neg ? irun_p1 + RW'(1) : '0;
`endif
          // Normal polarity takes priority if both runs complete together.
          if (match_pos && (run_p1 == RUN_LAST)) begin
            state_nx   = LOCK;
            lock_nx    = 1'b1;
            err_cnt_nx = '0;
            win_cnt_nx = '0;
            win_err_nx = '0;
            inv_nx     = 1'b0;
          end
`ifdef MSYNC_INVERT_EN
          else if (match_neg && (irun_p1 == RUN_LAST)) begin
            state_nx   = LOCK;
            lock_nx    = 1'b1;
            err_cnt_nx = '0;
            win_cnt_nx = '0;
            win_err_nx = '0;
            inv_nx     = 1'b1;
          end
`endif
        end

        LOCK: begin
          if (!match) begin
            err_nx     = 1'b1;
            err_cnt_nx = sat_inc(err_cnt_p1);
          end
          // Unlock is evaluated before the window wrap so that an error on
          // the last bit of a window still counts toward that window.
          if (!match && (win_err_p1 == ERR_LAST)) begin
            state_nx = SEARCH;
            lock_nx  = 1'b0;
            fill_nx  = '0;
            inv_nx   = 1'b0;
          end else if (win_cnt_p1 == WIN_LAST) begin
            win_cnt_nx = '0;
            win_err_nx = '0;
          end else begin
            win_cnt_nx = win_cnt_p1 + WW'(1);
            win_err_nx = win_err_p1 + (match ? EW'(0) : EW'(1));
          end
        end

        default: begin
          state_nx = SEARCH;
          fill_nx  = '0;
          lock_nx  = 1'b0;
          inv_nx   = 1'b0;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_sig) begin
    if (rst_sig) begin
      state_p1   <= SEARCH;
      hist_p1    <= '0;
      fill_p1    <= '0;
      run_p1     <= '0;
      win_cnt_p1 <= '0;
      win_err_p1 <= '0;
      lock_p1    <= 1'b0;
      err_p1     <= 1'b0;
      err_cnt_p1 <= '0;
      inv_p1     <= 1'b0;
`ifdef MSYNC_INVERT_EN
      irun_p1    <= '0;
`endif
    end else begin
      state_p1   <= state_nx;
      hist_p1    <= hist_nx;
      fill_p1    <= fill_nx;
      run_p1     <= run_nx;
      win_cnt_p1 <= win_cnt_nx;
      win_err_p1 <= win_err_nx;
      lock_p1    <= lock_nx;
      err_p1     <= err_nx;
      err_cnt_p1 <= err_cnt_nx;
      inv_p1     <= inv_nx;
`ifdef MSYNC_INVERT_EN
      irun_p1    <= irun_nx;
`endif
    end
  end

  assign bus.lock_sig    = lock_p1;
  assign bus.err_sig     = err_p1;
  assign bus.err_cnt_sig = err_cnt_p1;
`ifdef MSYNC_INVERT_EN
  assign bus.inv_sig     = inv_p1;
`else
  assign bus.inv_sig     = 1'b0;
`endif

endmodule
